// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-command signals of mem_port_arbiter, bundled with
// modports for the arbiter (slave) and the core/memory environment (master).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Request channels: a transfer happens in a cycle where valid && ready;
  // the requester holds valid and payload stable until that cycle, ready is
  // combinational, and responses are one-cycle pulses with no back-pressure.
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;

  logic              d_req_valid;
  logic              d_req_we;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_wdata;
  logic [BE_W-1:0]   d_req_be;
  logic              d_req_ready;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_be,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata,
    output busy
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_be,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-port SRAM (data has priority).
// Define MEM_ARB_AGING_EN to force a fetch grant after STARVE_LIMIT denied cycles.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);
  localparam int BE_W = DATA_W / 8;

  logic grant_if;
  logic grant_d;

`ifdef MEM_ARB_AGING_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;
  logic             force_if;

  assign force_if = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_if = bus.if_req_valid && (!bus.d_req_valid || force_if);

  // Counts consecutive cycles fetch waited; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!bus.if_req_valid || grant_if) begin
      starve_cnt <= '0;
    end else if (!force_if) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  assign grant_if = bus.if_req_valid && !bus.d_req_valid;
`endif

  assign grant_d         = bus.d_req_valid && !grant_if;
  assign bus.if_req_ready = grant_if;
  assign bus.d_req_ready  = grant_d;

  // Stage C: the registered memory command plus the owner of a read.
  logic              c_en;
  logic              c_we;
  logic              c_own_if;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [BE_W-1:0]   c_be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_en     <= 1'b0;
      c_we     <= 1'b0;
      c_own_if <= 1'b0;
      c_addr   <= '0;
      c_wdata  <= '0;
      c_be     <= '0;
    end else begin
      c_en     <= grant_if || grant_d;
      c_we     <= grant_d && bus.d_req_we;
      c_own_if <= grant_if;
      if (grant_d) begin
        c_addr  <= bus.d_req_addr;
        c_wdata <= bus.d_req_wdata;
        c_be    <= bus.d_req_be;
      end else if (grant_if) begin
        c_addr  <= bus.if_req_addr;
        c_wdata <= '0;
        c_be    <= '1;
      end
    end
  end

  assign bus.mem_en    = c_en;
  assign bus.mem_we    = c_we;
  assign bus.mem_addr  = c_addr;
  assign bus.mem_wdata = c_wdata;
  assign bus.mem_be    = c_be;

  // Stage R: only reads advance, since stores return nothing.
  logic r_if;
  logic r_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if <= 1'b0;
      r_d  <= 1'b0;
    end else begin
      r_if <= c_en && !c_we && c_own_if;
      r_d  <= c_en && !c_we && !c_own_if;
    end
  end

  assign bus.if_rsp_valid = r_if;
  assign bus.d_rsp_valid  = r_d;
  assign bus.if_rsp_data  = r_if ? bus.mem_rdata : '0;
  assign bus.d_rsp_data   = r_d  ? bus.mem_rdata : '0;
  assign bus.busy         = c_en || r_if || r_d;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random bench for mem_port_arbiter against a transaction-level model
// (grant rule, word-array memory, expected command/response queues keyed by cycle).
module tb_mem_port_arbiter;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int BE_W         = DATA_W / 8;
  localparam int STARVE_LIMIT = 4;
`ifdef MEM_ARB_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // SRAM environment: registered read data, byte-enabled writes.
  logic [DATA_W-1:0] sram [0:63];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < BE_W; b++)
          if (bus.mem_be[b]) sram[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= sram[bus.mem_addr[7:2]];
      end
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [0:63];
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                denied = 0;
  bit                acc_if, acc_d;
  int                cmd_cyc_q[$];
  logic [ADDR_W-1:0] cmd_addr_q[$];
  logic              cmd_we_q[$];
  logic [DATA_W-1:0] cmd_wdata_q[$];
  logic [BE_W-1:0]   cmd_be_q[$];
  int                rsp_cyc_q[$];
  logic              rsp_own_q[$];
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_cmd(input int c, input logic [ADDR_W-1:0] a, input logic we,
                          input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be);
    cmd_cyc_q.push_back(c); cmd_addr_q.push_back(a); cmd_we_q.push_back(we);
    cmd_wdata_q.push_back(wd); cmd_be_q.push_back(be);
  endtask

  task automatic push_rsp(input int c, input logic own_if, input logic [DATA_W-1:0] d);
    rsp_cyc_q.push_back(c); rsp_own_q.push_back(own_if); exp_q.push_back(d);
  endtask

  // One clock cycle: predict and check at the falling edge, then advance.
  task automatic step();
    bit exp_if_rdy, exp_d_rdy, exp_en, exp_rv, starved;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
      chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      chk("rst_mem_be", 64'(bus.mem_be), 64'd0);
      chk("rst_if_rsp_valid", 64'(bus.if_rsp_valid), 64'd0);
      chk("rst_d_rsp_valid", 64'(bus.d_rsp_valid), 64'd0);
      chk("rst_if_rsp_data", 64'(bus.if_rsp_data), 64'd0);
      chk("rst_d_rsp_data", 64'(bus.d_rsp_data), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      cmd_cyc_q.delete(); cmd_addr_q.delete(); cmd_we_q.delete();
      cmd_wdata_q.delete(); cmd_be_q.delete();
      rsp_cyc_q.delete(); rsp_own_q.delete(); exp_q.delete();
      denied = 0; acc_if = 0; acc_d = 0;
    end else begin
      starved    = AGING && (denied >= STARVE_LIMIT);
      exp_if_rdy = bus.if_req_valid && (!bus.d_req_valid || starved);
      exp_d_rdy  = bus.d_req_valid && !exp_if_rdy;
      chk("if_req_ready", 64'(bus.if_req_ready), 64'(exp_if_rdy));
      chk("d_req_ready", 64'(bus.d_req_ready), 64'(exp_d_rdy));
      acc_if = exp_if_rdy;
      acc_d  = exp_d_rdy;
      if (acc_d) begin
        if (bus.d_req_we) begin
          push_cmd(cyc + 1, bus.d_req_addr, 1'b1, bus.d_req_wdata, bus.d_req_be);
          for (int b = 0; b < BE_W; b++)
            if (bus.d_req_be[b])
              ref_mem[bus.d_req_addr[7:2]][8*b +: 8] = bus.d_req_wdata[8*b +: 8];
        end else begin
          push_cmd(cyc + 1, bus.d_req_addr, 1'b0, '0, '1);
          push_rsp(cyc + 2, 1'b0, ref_mem[bus.d_req_addr[7:2]]);
        end
      end else if (acc_if) begin
        push_cmd(cyc + 1, bus.if_req_addr, 1'b0, '0, '1);
        push_rsp(cyc + 2, 1'b1, ref_mem[bus.if_req_addr[7:2]]);
      end
      denied = (bus.if_req_valid && !acc_if) ? denied + 1 : 0;

      exp_en = (cmd_cyc_q.size() > 0) && (cmd_cyc_q[0] == cyc);
      chk("mem_en", 64'(bus.mem_en), 64'(exp_en));
      if (exp_en) begin
        chk("mem_addr", 64'(bus.mem_addr), 64'(cmd_addr_q[0]));
        chk("mem_we", 64'(bus.mem_we), 64'(cmd_we_q[0]));
        if (cmd_we_q[0]) begin
          chk("mem_wdata", 64'(bus.mem_wdata), 64'(cmd_wdata_q[0]));
          chk("mem_be", 64'(bus.mem_be), 64'(cmd_be_q[0]));
        end
        void'(cmd_cyc_q.pop_front()); void'(cmd_addr_q.pop_front());
        void'(cmd_we_q.pop_front()); void'(cmd_wdata_q.pop_front());
        void'(cmd_be_q.pop_front());
      end

      exp_rv = (rsp_cyc_q.size() > 0) && (rsp_cyc_q[0] == cyc);
      chk("if_rsp_valid", 64'(bus.if_rsp_valid), 64'(exp_rv && rsp_own_q[0]));
      chk("d_rsp_valid", 64'(bus.d_rsp_valid), 64'(exp_rv && !rsp_own_q[0]));
      if (exp_rv) begin
        if (rsp_own_q[0]) chk("if_rsp_data", 64'(bus.if_rsp_data), 64'(exp_q[0]));
        else              chk("d_rsp_data", 64'(bus.d_rsp_data), 64'(exp_q[0]));
        void'(rsp_cyc_q.pop_front()); void'(rsp_own_q.pop_front()); void'(exp_q.pop_front());
      end
      chk("busy", 64'(bus.busy), 64'(exp_en || exp_rv));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      sram[i]    = DATA_W'($urandom);
      ref_mem[i] = sram[i];
    end
    sram[6'h40]    = 32'h0050_0093; ref_mem[6'h40] = 32'h0050_0093;
    sram[6'h20]    = 32'h1122_3344; ref_mem[6'h20] = 32'h1122_3344;
    bus.if_req_valid = 1'b0; bus.if_req_addr = '0;
    bus.d_req_valid = 1'b0; bus.d_req_we = 1'b0; bus.d_req_addr = '0;
    bus.d_req_wdata = '0; bus.d_req_be = '0;
    bus.mem_rdata = '0;

    // Reset state.
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Single fetch of 0x100.
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h100;
    step();
    bus.if_req_valid = 1'b0;
    idle(3);

    // Conflict: data wins, fetch accepted one cycle later.
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h0;
    bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0; bus.d_req_addr = 32'h200;
    step();
    bus.d_req_valid = 1'b0;
    step();
    bus.if_req_valid = 1'b0;
    idle(3);

    // Store then fetch of the same address.
    bus.d_req_valid = 1'b1; bus.d_req_we = 1'b1; bus.d_req_addr = 32'h40;
    bus.d_req_wdata = 32'hDEAD_BEEF; bus.d_req_be = 4'hF;
    step();
    bus.d_req_valid = 1'b0;
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h40;
    step();
    bus.if_req_valid = 1'b0;
    idle(3);

    // Byte store followed by back-to-back loads.
    bus.d_req_valid = 1'b1; bus.d_req_we = 1'b1; bus.d_req_addr = 32'h80;
    bus.d_req_wdata = 32'h0000_00AA; bus.d_req_be = 4'h1;
    step();
    bus.d_req_we = 1'b0;
    step();
    bus.d_req_addr = 32'h84;
    step();
    bus.d_req_valid = 1'b0;
    idle(3);

    // Continuous data traffic with a waiting fetch.
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h8;
    bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.d_req_addr = ADDR_W'($urandom_range(0, 63)) << 2;
      step();
      if (acc_if) bus.if_req_addr = ADDR_W'($urandom_range(0, 63)) << 2;
    end
    bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
    idle(3);

    // Reset in the cycle after a load is accepted.
    bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0; bus.d_req_addr = 32'h10;
    step();
    bus.d_req_valid = 1'b0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(4);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if (!bus.if_req_valid && $urandom_range(0, 1) == 1) begin
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = ADDR_W'($urandom_range(0, 63)) << 2;
      end
      if (!bus.d_req_valid && $urandom_range(0, 2) != 0) begin
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = 1'($urandom_range(0, 1));
        bus.d_req_addr  = ADDR_W'($urandom_range(0, 63)) << 2;
        bus.d_req_wdata = DATA_W'($urandom);
        bus.d_req_be    = BE_W'($urandom_range(0, 15));
      end
      step();
      if (acc_if) bus.if_req_valid = 1'b0;
      if (acc_d)  bus.d_req_valid = 1'b0;
    end
    bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous SRAM between the core's instruction-fetch port and its load/store port. It accepts at most one request per cycle, gives data accesses priority, and registers the chosen command toward memory. Read data is routed back to the owning requester with fixed latency. It sits between the core's fetch/LSU request channels and the unified code/data memory; the core stalls on `*_req_ready` low.

## Interface
- `ADDR_W`, default 32: address width of all request channels and the memory.
- `DATA_W`, default 32: data width; `DATA_W/8` byte enables.
- `STARVE_LIMIT`, default 4: consecutive fetch-denied cycles before a forced fetch grant (aging only).

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `if_req_valid`  in  1  fetch read request.
- `if_req_addr`  in  ADDR_W  fetch byte address.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_rsp_valid`  out  1  fetch read data valid (one-cycle pulse).
- `if_rsp_data`  out  DATA_W  fetch read data.
- `d_req_valid`  in  1  load/store request.
- `d_req_we`  in  1  1 = store, 0 = load.
- `d_req_addr`  in  ADDR_W  data byte address.
- `d_req_wdata`  in  DATA_W  store data.
- `d_req_be`  in  DATA_W/8  store byte enables.
- `d_req_ready`  out  1  data request accepted this cycle.
- `d_rsp_valid`  out  1  load data valid (one-cycle pulse).
- `d_rsp_data`  out  DATA_W  load data.
- `mem_en`, `mem_we`  out  1 each  memory command strobe and write enable.
- `mem_addr`  out  ADDR_W  memory command address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_be`  out  DATA_W/8  memory byte enables.
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after `mem_en && !mem_we`.
- `busy`  out  1  any command or response in flight.

## Operation
- The handshake is `valid && ready`. `*_req_ready` is combinational from both valids and the grant logic. Requesters hold valid and payload stable until accepted.
- Grant: if `d_req_valid`, data wins; otherwise fetch wins if `if_req_valid`. Exactly one of the two readies is high when any valid is high, and both are low when neither is.
- Stage C (command register): an accepted request loads `mem_*` and an owner tag (IF/D, read/write). `mem_en` is high only when the stage holds a request. The memory never back-pressures, so the stage advances every cycle and the arbiter accepts every cycle.
- Stage R (response): the tag from C moves to R. `mem_rdata` is forwarded combinationally to the owner's `*_rsp_data`, with `*_rsp_valid` high for one cycle. Stores produce no response.
- There is no response back-pressure; requesters must sink responses.
- Ordering: commands reach memory in grant order, so a store followed by a fetch of the same address returns the new data.
- `busy` = C valid | R valid.

## Timing
- Reset values: all `mem_*` = 0, both `*_rsp_valid` = 0, `*_rsp_data` = 0, `busy` = 0, stages empty, starvation counter = 0.
- Request accepted in cycle N: `mem_en` high in N+1, `*_rsp_valid` high in N+2. Read latency is 2 cycles.
- Throughput is one request per cycle. Back-to-back loads give responses on consecutive cycles.
- Both valid in the same cycle: only data is accepted; fetch stays pending with `if_req_ready` = 0.
- Reset asserted mid-operation: stages clear immediately, and in-flight responses are dropped (no `rsp_valid` after reset release).
- Valid dropping without acceptance is a protocol violation and is not checked.

## Configuration
- `MEM_ARB_AGING_EN` defined: a saturating counter counts cycles in which `if_req_valid` is high and fetch is not granted. When the counter equals `STARVE_LIMIT`, the next grant goes to fetch even if `d_req_valid` is high. The counter resets to 0 on any fetch grant or when `if_req_valid` is low.
- Not defined: strict data priority, and the counter logic is absent. Fetch can starve indefinitely under continuous data traffic.

## Test plan
- Single fetch: `if_req_addr` = 0x100 in cycle 0, memory word 0x00500093. Expect `mem_en` with addr 0x100 in cycle 1, and `if_rsp_valid` with data 0x00500093 in cycle 2.
- Conflict: both valid in cycle 0 (fetch 0x0, load 0x200). Expect `d_req_ready` = 1 and `if_req_ready` = 0 in cycle 0, fetch accepted in cycle 1, `d_rsp_valid` in cycle 2, `if_rsp_valid` in cycle 3.
- Store then fetch of the same address: store 0xDEADBEEF to 0x40 with be = 0xF, then fetch 0x40. Expect `if_rsp_data` = 0xDEADBEEF, and no `d_rsp_valid` for the store.
- Byte store: be = 0x1 with wdata 0x000000AA to a word holding 0x11223344. A subsequent load returns 0x112233AA.
- Aging (macro on, `STARVE_LIMIT` = 4): continuous data valid plus fetch valid. Fetch is granted exactly in cycle 4, then data again. With the macro off, fetch is never granted.
- Reset in the cycle after a load is accepted: no `d_rsp_valid` afterwards; all outputs read 0 during reset.
